masku_operand_gather: RTL

- Upstream stage of the MASKU operand sequencer.
- Collects one operand word per lane from NrLanes independent lane valid/ready streams and aligns them into one full-width beat in lane-interleaved layout.
- Buffers up to two beats and tags each beat with its valid element count and a last flag.
- Tracks vl so that the final partial beat takes only the lanes that carry data. The output feeds the sequencer combinationally.

---
 rtl/masku_operand_gather_if.sv | 26 ++
 rtl/masku_operand_gather.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/masku_operand_gather_if.sv
// Lane-side and sequencer-side streams of the MASKU operand gather stage.
// The slave modport is the gather block; the master modport is its environment.
interface masku_operand_gather_if #(
  parameter int NrLanes   = 4,
  parameter int DataWidth = 64,
  parameter int VlWidth   = 16
) ();
  logic [NrLanes*DataWidth-1:0] lane_operand_i;
  logic [NrLanes-1:0]           lane_valid_i;
  logic [NrLanes-1:0]           lane_ready_o;
  logic [NrLanes*DataWidth-1:0] operand_o;
  logic [VlWidth-1:0]           operand_elems_o;
  logic                         operand_last_o;
  logic                         operand_valid_o;
  logic                         operand_ready_i;

  modport slave (
    input  lane_operand_i, lane_valid_i, operand_ready_i,
    output lane_ready_o, operand_o, operand_elems_o, operand_last_o, operand_valid_o
  );

  modport master (
    output lane_operand_i, lane_valid_i, operand_ready_i,
    input  lane_ready_o, operand_o, operand_elems_o, operand_last_o, operand_valid_o
  );
endinterface

// File: rtl/masku_operand_gather.sv
// Gathers one word per lane into lane-interleaved beats, tags them with element
// count and last flag, and buffers up to two beats for the MASKU sequencer.
module masku_operand_gather #(
  parameter int NrLanes   = 4,
  parameter int DataWidth = 64,
  parameter int VlWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [VlWidth-1:0]   vl_i,
  input  logic [1:0]           vsew_i,
  output logic                 busy_o,
  output logic                 done_o,
  masku_operand_gather_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GATHER, DRAIN} state_e;

  localparam int BeatWidth = NrLanes * DataWidth;

  state_e                 state_q, state_d;
  logic [1:0]             vsew_q, vsew_d;
  logic [VlWidth-1:0]     rem_q, rem_d;
  logic [NrLanes-1:0]     staged_q, staged_d;
  logic [BeatWidth-1:0]   stage_q, stage_d;
  logic [BeatWidth-1:0]   fifo_data_q [2];
  logic [BeatWidth-1:0]   fifo_data_d [2];
  logic [VlWidth-1:0]     fifo_elems_q [2];
  logic [VlWidth-1:0]     fifo_elems_d [2];
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   done_q, done_d;

  logic [VlWidth-1:0]     epb;
  logic [VlWidth-1:0]     beat_elems;
  logic                   beat_last;
  logic [BeatWidth-1:0]   beat_data;
  logic [NrLanes-1:0]     lane_need;
  logic [NrLanes-1:0]     lane_ready;
  logic                   all_staged;
  logic                   push;
  logic                   pop;

  assign epb        = VlWidth'(NrLanes) << (2'd3 - vsew_q);
  assign beat_last  = (rem_q <= epb);
  assign beat_elems = beat_last ? rem_q : epb;

  // Lane l is needed iff l < min(NrLanes, rem), which reduces to l < rem.
  always_comb begin
    lane_need = '0;
    beat_data = '0;
    for (int l = 0; l < NrLanes; l++) begin
      lane_need[l] = (rem_q > VlWidth'(l));
      if (lane_need[l]) begin
        beat_data[l*DataWidth +: DataWidth] = stage_q[l*DataWidth +: DataWidth];
      end
    end
  end

  assign lane_ready = (state_q == GATHER) ? (lane_need & ~staged_q) : '0;
  assign all_staged = &(staged_q | ~lane_need);
  assign pop        = (count_q != 2'd0) && bus.operand_ready_i;
  assign push       = (state_q == GATHER) && all_staged && ((count_q != 2'd2) || pop);

  always_comb begin
    state_d      = state_q;
    vsew_d       = vsew_q;
    rem_d        = rem_q;
    staged_d     = staged_q;
    stage_d      = stage_q;
    fifo_data_d  = fifo_data_q;
    fifo_elems_d = fifo_elems_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    done_d       = 1'b0;

    for (int l = 0; l < NrLanes; l++) begin
      if (bus.lane_valid_i[l] && lane_ready[l]) begin
        stage_d[l*DataWidth +: DataWidth] = bus.lane_operand_i[l*DataWidth +: DataWidth];
        staged_d[l] = 1'b1;
      end
    end

    // Captures and formation never overlap: formation needs every needed lane staged.
    if (push) begin
      staged_d               = '0;
      rem_d                  = rem_q - beat_elems;
      fifo_data_d[wr_ptr_q]  = beat_data;
      fifo_elems_d[wr_ptr_q] = beat_elems;
      fifo_last_d[wr_ptr_q]  = beat_last;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (vl_i != '0) begin
            state_d = GATHER;
            vsew_d  = vsew_i;
            rem_d   = vl_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      GATHER: begin
        if (push && beat_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (count_q == 2'd1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      vsew_q       <= '0;
      rem_q        <= '0;
      staged_q     <= '0;
      stage_q      <= '0;
      fifo_data_q  <= '{default: '0};
      fifo_elems_q <= '{default: '0};
      fifo_last_q  <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsew_q       <= vsew_d;
      rem_q        <= rem_d;
      staged_q     <= staged_d;
      stage_q      <= stage_d;
      fifo_data_q  <= fifo_data_d;
      fifo_elems_q <= fifo_elems_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
    end
  end

  assign bus.lane_ready_o    = lane_ready;
  assign bus.operand_o       = fifo_data_q[rd_ptr_q];
  assign bus.operand_elems_o = fifo_elems_q[rd_ptr_q];
  assign bus.operand_last_o  = fifo_last_q[rd_ptr_q];
  assign bus.operand_valid_o = (count_q != 2'd0);
  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_q;

endmodule
